// File: rtl/shift_reg_var.sv
// shift_reg_var
//   Stallable, flushable delay line. CH lanes of DATA bits travel together with
//   one shared valid bit through MAX_SHIFT register stages. The output is tapped
//   from the stage selected at runtime by dly_sel, clamped to 1..MAX_SHIFT, so a
//   sample appears d_eff advancing edges after it was captured.
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high clear of every stage
//   en        in   1 = line advances on this edge, 0 = every stage holds
//   flush     in   synchronous clear of every stage, overrides en
//   dly_sel   in   requested delay in advancing cycles (0 acts as 1)
//   in_valid  in   qualifier captured alongside data_in
//   data_in   in   CH*DATA bits, lane k at [k*DATA +: DATA]
//   out_valid out  valid bit at the selected tap
//   data_out  out  data at the selected tap
//   busy      out  OR of the valid bits in stages 0..d_eff-1
module shift_reg_var #(
  parameter int MAX_SHIFT = 8,
  parameter int DATA      = 32,
  parameter int CH        = 1,
  localparam int DW       = $clog2(MAX_SHIFT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               flush,
  input  logic [DW-1:0]      dly_sel,
  input  logic               in_valid,
  input  logic [CH*DATA-1:0] data_in,
  output logic               out_valid,
  output logic [CH*DATA-1:0] data_out,
  output logic               busy
);

  localparam int W = CH * DATA;

  logic [W-1:0]         data_r [MAX_SHIFT];
  logic [MAX_SHIFT-1:0] valid_r;
  logic [DW-1:0]        d_eff_s;
  logic [W-1:0]         tap_data_s;
  logic                 tap_valid_s;
  logic                 busy_s;

  // Clamp the requested delay into the range of existing stages.
  always_comb begin
    d_eff_s = dly_sel;
    if (dly_sel == {DW{1'b0}}) begin
      d_eff_s = DW'(1);
    end else if (dly_sel > DW'(MAX_SHIFT)) begin
      d_eff_s = DW'(MAX_SHIFT);
    end else begin
      d_eff_s = dly_sel;
    end
  end

  // AND-OR tap mux over stage[d_eff-1]; busy covers every stage up to the tap.
  // Only registers feed this, so data_in never reaches data_out combinationally.
  always_comb begin
    tap_data_s  = {W{1'b0}};
    tap_valid_s = 1'b0;
    busy_s      = 1'b0;
    for (int i = 0; i < MAX_SHIFT; i++) begin
      tap_data_s  = tap_data_s | (data_r[i] & {W{d_eff_s == DW'(i + 1)}});
      tap_valid_s = tap_valid_s | (valid_r[i] & (d_eff_s == DW'(i + 1)));
      busy_s      = busy_s | (valid_r[i] & (DW'(i) < d_eff_s));
    end
  end

  // Stage storage: reset, then flush, then advance, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= {MAX_SHIFT{1'b0}};
      for (int i = 0; i < MAX_SHIFT; i++) begin
        data_r[i] <= {W{1'b0}};
      end
    end else if (flush) begin
      // The sample presented in a flush cycle is dropped along with the line.
      valid_r <= {MAX_SHIFT{1'b0}};
      for (int i = 0; i < MAX_SHIFT; i++) begin
        data_r[i] <= {W{1'b0}};
      end
    end else if (en) begin
      // Data is captured whatever in_valid is; the valid bit qualifies it.
      valid_r[0] <= in_valid;
      data_r[0]  <= data_in;
      for (int i = 1; i < MAX_SHIFT; i++) begin
        valid_r[i] <= valid_r[i-1];
        data_r[i]  <= data_r[i-1];
      end
    end else begin
      valid_r <= valid_r;
      for (int i = 0; i < MAX_SHIFT; i++) begin
        data_r[i] <= data_r[i];
      end
    end
  end

  assign out_valid = tap_valid_s;
  assign data_out  = tap_data_s;
  assign busy      = busy_s;

endmodule

// File: tb/tb_shift_reg_var.sv
// tb_shift_reg_var
//   Directed scenarios followed by a randomized run of shift_reg_var
//   (MAX_SHIFT=8, DATA=16, CH=4). The reference keeps a log of every sample
//   accepted on an advancing edge; the expected tap for delay d is the entry
//   d positions from the end of the log, unless a flush or reset has since
//   invalidated it.
module tb_shift_reg_var;

  localparam int MS = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        flush;
  logic [3:0]  dly_sel;
  logic        in_valid;
  logic [63:0] data_in;
  logic        out_valid;
  logic [63:0] data_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference log of accepted samples; entries below 'base' were cleared.
  logic [63:0] log_d[$];
  bit          log_v[$];
  int          base = 0;

  shift_reg_var #(.MAX_SHIFT(MS), .DATA(16), .CH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .dly_sel(dly_sel),
    .in_valid(in_valid), .data_in(data_in),
    .out_valid(out_valid), .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int clampd(int s);
    if (s < 1) return 1;
    if (s > MS) return MS;
    return s;
  endfunction

  task automatic check(string tag);
    int d, n, idx;
    logic        ev, eb;
    logic [63:0] ed;
    d = clampd(int'(dly_sel));
    n = log_d.size();
    idx = n - d;
    ev = 1'b0; ed = 64'h0; eb = 1'b0;
    if (idx >= base) begin
      ev = log_v[idx];
      ed = log_d[idx];
    end
    for (int k = idx; k < n; k++) begin
      if (k >= base && k >= 0) eb = eb | log_v[k];
    end
    checks += 3;
    assert (out_valid === ev) else begin
      errors++;
      $error("FAIL %s out_valid: got %0b expected %0b", tag, out_valid, ev);
    end
    assert (data_out === ed) else begin
      errors++;
      $error("FAIL %s data_out: got %h expected %h", tag, data_out, ed);
    end
    assert (busy === eb) else begin
      errors++;
      $error("FAIL %s busy: got %0b expected %0b", tag, busy, eb);
    end
  endtask

  task automatic check_bit(string tag, logic got, logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic check_word(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(bit e, bit f, logic [3:0] ds, bit v, logic [63:0] d);
    en = e; flush = f; dly_sel = ds; in_valid = v; data_in = d;
  endtask

  // One clock: update the reference at the edge, compare on the falling edge.
  task automatic tick(string tag);
    @(posedge clk);
    if (flush) begin
      base = log_d.size();
    end else if (en) begin
      log_d.push_back(data_in);
      log_v.push_back(in_valid);
    end
    @(negedge clk);
    check(tag);
  endtask

  // Assert reset mid-cycle; outputs must drop before any further edge.
  task automatic do_reset(string tag);
    #2;
    reset = 1'b1;
    base = log_d.size();
    #1;
    check_bit({tag, "_async_valid"}, out_valid, 1'b0);
    check_word({tag, "_async_data"}, data_out, 64'h0);
    check_bit({tag, "_async_busy"}, busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_hold"});
    reset = 1'b0;
  endtask

  initial begin
    int dl[3];
    dl[0] = 1; dl[1] = 4; dl[2] = 8;
    reset = 1'b1;
    drive(1'b1, 1'b0, 4'd8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_init");
    reset = 1'b0;

    // Fill with nonzero data, then reset asynchronously.
    for (int i = 0; i < MS; i++) begin
      drive(1'b1, 1'b0, 4'd8, 1'b1, 64'h1234_0000_0000_0000 + 64'(i + 1));
      tick("fill");
    end
    check_bit("fill_busy", busy, 1'b1);
    do_reset("reset_mid");

    // Latency sweep: A5 must emerge exactly d edges after capture.
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 1'b1, 4'(dl[j]), 1'b0, 64'h0);
      tick("lat_flush");
      drive(1'b1, 1'b0, 4'(dl[j]), 1'b1, 64'h0000_0000_0000_00A5);
      tick("lat_cap");
      check_bit("lat_valid_edge1", out_valid, dl[j] == 1);
      for (int k = 2; k <= MS + 1; k++) begin
        drive(1'b1, 1'b0, 4'(dl[j]), 1'b0, 64'h0);
        tick("lat_run");
        check_bit("lat_valid_edge", out_valid, dl[j] == k);
        if (dl[j] == k) check_word("lat_data", data_out, 64'h0000_0000_0000_00A5);
      end
    end

    // Stall: send 1,2,3, freeze for 5 cycles with junk on the inputs, resume.
    drive(1'b1, 1'b1, 4'd3, 1'b0, 64'h0);
    tick("stall_flush");
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 4'd3, 1'b1, 64'(i));
      tick("stall_send");
    end
    check_word("stall_first", data_out, 64'h1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 4'd3, 1'b1, 64'hBAD0_0000_0000_0000 + 64'(i));
      tick("stall_hold");
      check_word("stall_frozen", data_out, 64'h1);
    end
    for (int i = 2; i <= 4; i++) begin
      drive(1'b1, 1'b0, 4'd3, 1'b0, 64'h0);
      tick("stall_resume");
      check_bit("stall_order_valid", out_valid, i <= 3);
      check_word("stall_order_data", data_out, (i <= 3) ? 64'(i) : 64'h0);
    end

    // Clamp: dly_sel 0 behaves as 1, dly_sel 15 behaves as 8.
    drive(1'b1, 1'b1, 4'd0, 1'b0, 64'h0);
    tick("clamp_flush");
    drive(1'b1, 1'b0, 4'd0, 1'b1, 64'h0000_0000_0000_0C01);
    tick("clamp0");
    check_word("clamp0_data", data_out, 64'h0000_0000_0000_0C01);
    for (int i = 0; i < MS; i++) begin
      drive(1'b1, 1'b0, 4'd15, (i == 0), (i == 0) ? 64'h0000_0000_0000_0C0F : 64'h0);
      tick("clamp15");
    end
    check_word("clamp15_data", data_out, 64'h0000_0000_0000_0C0F);

    // Flush a full line while a valid sample is presented.
    for (int i = 0; i < MS; i++) begin
      drive(1'b1, 1'b0, 4'd8, 1'b1, 64'h00F0_0000_0000_0000 + 64'(i));
      tick("flush_fill");
    end
    drive(1'b1, 1'b1, 4'd8, 1'b1, 64'h0000_0000_0000_DEAD);
    tick("flush_edge");
    check_bit("flush_valid", out_valid, 1'b0);
    check_bit("flush_busy", busy, 1'b0);
    for (int i = 0; i < MS + 1; i++) begin
      drive(1'b1, 1'b0, 4'd8, 1'b0, 64'h0);
      tick("flush_drain");
      check_bit("flush_never_out", out_valid, 1'b0);
    end

    // Multi-lane ordering.
    drive(1'b1, 1'b0, 4'd5, 1'b1, 64'h4444_3333_2222_1111);
    tick("lanes_cap");
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 4'd5, 1'b0, 64'h0);
      tick("lanes_run");
    end
    check_word("lanes_data", data_out, 64'h4444_3333_2222_1111);

    // Randomized run against the log model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 32) == 0,
            (($urandom % 16) == 0) ? 4'($urandom_range(0, 15)) : dly_sel,
            $urandom % 2, {$urandom, $urandom});
      if (($urandom % 100) == 0) begin
        do_reset("rand_reset");
      end else begin
        tick("rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
